// File: rtl/fanout_fork.sv
// fanout_fork: zero-latency one-to-many token fork.
//
// A single upstream token (in_valid/in_data/in_ready) is offered to every
// active output channel. The payload is shared by all channels and passed
// straight through; nothing is stored.
//
// Two fork flavours, chosen by cfg_eager:
//   eager - each channel may take the token in a different cycle; a
//           registered done vector remembers who has already been served,
//           and the token is retired once every active channel has it.
//   lazy  - the token is offered only when every active channel is ready,
//           so all of them accept it in the same cycle; done stays clear.
//
// Ports
//   CLK         sole clock, rising edge
//   RESET       synchronous active-high reset
//   in_valid    upstream token present
//   in_data     upstream payload [DATA_WIDTH]
//   in_ready    upstream token consumed this cycle (with in_valid)
//   out_valid   per-channel token offered [NUM_OUT]
//   out_data    shared payload, equal to in_data [DATA_WIDTH]
//   out_ready   per-channel downstream ready [NUM_OUT]
//   cfg_en      per-channel enable [NUM_OUT]
//   cfg_sel     per-channel route select [NUM_OUT]
//   cfg_eager   1 = eager fork, 0 = lazy fork
//   xfer_count  number of upstream tokens consumed, wrapping [CNT_WIDTH]
module fanout_fork #(
   parameter int NUM_OUT    = 6,
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic [NUM_OUT-1:0]    out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic [NUM_OUT-1:0]    out_ready,
   input  logic [NUM_OUT-1:0]    cfg_en,
   input  logic [NUM_OUT-1:0]    cfg_sel,
   input  logic                  cfg_eager,
   output logic [CNT_WIDTH-1:0]  xfer_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic [NUM_OUT-1:0] active;
   logic [NUM_OUT-1:0] rdy_ok;
   logic [NUM_OUT-1:0] done;
   logic               take;

   assign active = cfg_en & cfg_sel;

   // A channel does not hold up the token if it is not a target, has
   // already been served, or is ready now. A done bit left on a channel
   // that has since become inactive is harmless here: ~active already
   // covers it.
   assign rdy_ok = ~active | done | out_ready;

   assign in_ready = (&rdy_ok) & ~RESET;
   assign take     = in_valid & in_ready;
   assign out_data = in_data;

   always_comb begin
      out_valid = '0;
      if (!RESET) begin
         if (cfg_eager)
            out_valid = {NUM_OUT{in_valid}} & active & ~done;
         else
            out_valid = {NUM_OUT{take}} & active;
      end
   end

   // done: cleared on reset, in lazy mode and when the token retires;
   // otherwise accumulates the channels that handshook this cycle. With
   // in_valid low, out_valid is zero, so done simply holds.
   always_ff @(posedge CLK) begin
      if (RESET)
         done <= '0;
      else if (!cfg_eager || take)
         done <= '0;
      else
         done <= done | (out_valid & out_ready);
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         xfer_count <= '0;
      else if (take)
         xfer_count <= xfer_count + CNT_ONE;
   end

endmodule

// File: tb/tb_fanout_fork.sv
// Scoreboard bench for fanout_fork (NUM_OUT=6, DATA_WIDTH=16, CNT_WIDTH=4).
// Stimulus drives one vector per cycle just after the rising edge and
// pushes the hand-computed response; a separate monitor pops and compares
// on each falling edge.
module tb_fanout_fork;

   localparam int NO = 6;
   localparam int DW = 16;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [NO-1:0] out_valid;
   logic [DW-1:0] out_data;
   logic [NO-1:0] out_ready;
   logic [NO-1:0] cfg_en;
   logic [NO-1:0] cfg_sel;
   logic          cfg_eager;
   logic [CW-1:0] xfer_count;

   typedef struct {
      string         name;
      logic          ir;
      logic [NO-1:0] ov;
      logic [DW-1:0] od;
      logic [CW-1:0] xc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   fanout_fork #(.NUM_OUT(NO), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .cfg_en(cfg_en), .cfg_sel(cfg_sel),
      .cfg_eager(cfg_eager), .xfer_count(xfer_count)
   );

   always #5 CLK = ~CLK;

   task automatic step(input string name, input logic rst, input logic iv,
                       input logic [DW-1:0] id, input logic [NO-1:0] en,
                       input logic [NO-1:0] sel, input logic eager,
                       input logic [NO-1:0] ordy, input logic e_ir,
                       input logic [NO-1:0] e_ov, input logic [CW-1:0] e_xc);
      exp_t e;
      @(posedge CLK);
      #1;
      RESET = rst; in_valid = iv; in_data = id; cfg_en = en;
      cfg_sel = sel; cfg_eager = eager; out_ready = ordy;
      e.name = name; e.ir = e_ir; e.ov = e_ov; e.od = id; e.xc = e_xc;
      q.push_back(e);
   endtask

   // Monitor: compares every output the DUT presents in a driven cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (q.size() > 0) begin
            e = q.pop_front();
            total++;
            if (in_ready !== e.ir) begin
               bad++;
               $display("FAIL %s in_ready got=%b want=%b", e.name, in_ready, e.ir);
            end
            total++;
            if (out_valid !== e.ov) begin
               bad++;
               $display("FAIL %s out_valid got=%b want=%b", e.name, out_valid, e.ov);
            end
            total++;
            if (out_data !== e.od) begin
               bad++;
               $display("FAIL %s out_data got=%h want=%h", e.name, out_data, e.od);
            end
            total++;
            if (xfer_count !== e.xc) begin
               bad++;
               $display("FAIL %s xfer_count got=%0d want=%0d", e.name, xfer_count, e.xc);
            end
         end
      end
   end

   initial begin
      RESET = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = '0;
      cfg_en = '1; cfg_sel = 6'b000111; cfg_eager = 1'b0;

      // Reset: nothing offered, nothing accepted.
      step("rst_hold", 1, 1, 16'h0bad, 6'h3f, 6'b000111, 0, 6'h3f, 0, 6'b000000, 0);

      // Lazy: one active channel not ready blocks everyone.
      step("lazy_block", 0, 1, 16'h1234, 6'h3f, 6'b000111, 0, 6'b000011, 0, 6'b000000, 0);
      step("lazy_go",    0, 1, 16'h1234, 6'h3f, 6'b000111, 0, 6'b000111, 1, 6'b000111, 0);
      step("lazy_idle",  0, 0, 16'h0000, 6'h3f, 6'b000111, 0, 6'b000000, 0, 6'b000000, 1);

      // Eager: channels served one per cycle.
      step("eager_c0",   0, 1, 16'habcd, 6'h3f, 6'b000111, 1, 6'b000001, 0, 6'b000111, 1);
      step("eager_c1",   0, 1, 16'habcd, 6'h3f, 6'b000111, 1, 6'b000010, 0, 6'b000110, 1);
      step("eager_c2",   0, 1, 16'habcd, 6'h3f, 6'b000111, 1, 6'b000100, 1, 6'b000100, 1);
      step("eager_idle", 0, 0, 16'h0000, 6'h3f, 6'b000111, 1, 6'b000000, 0, 6'b000000, 2);

      // Eager: done holds across an in_valid gap.
      step("hold_a",     0, 1, 16'h7777, 6'h3f, 6'b000111, 1, 6'b000001, 0, 6'b000111, 2);
      step("hold_gap",   0, 0, 16'h7777, 6'h3f, 6'b000111, 1, 6'b000000, 0, 6'b000000, 2);
      step("hold_back",  0, 1, 16'h7777, 6'h3f, 6'b000111, 1, 6'b000000, 0, 6'b000110, 2);
      step("hold_fin",   0, 1, 16'h7777, 6'h3f, 6'b000111, 1, 6'b000110, 1, 6'b000110, 2);

      // Reset mid-token discards partial delivery.
      step("mid_part",   0, 1, 16'h5555, 6'h3f, 6'b000111, 1, 6'b000011, 0, 6'b000111, 3);
      step("mid_rst",    1, 1, 16'h5555, 6'h3f, 6'b000111, 1, 6'b000100, 0, 6'b000000, 3);
      step("mid_after",  0, 1, 16'h5555, 6'h3f, 6'b000111, 1, 6'b000000, 0, 6'b000111, 0);

      // No active channel: tokens dropped, still counted.
      for (int i = 0; i < 5; i++)
         step("none_act", 0, 1, 16'(16'h0100 + i), 6'h00, 6'b000111, 1, 6'b000000, 1, 6'b000000, CW'(i));
      step("none_idle",  0, 0, 16'h0000, 6'h00, 6'b000111, 1, 6'b000000, 1, 6'b000000, 5);

      // Counter wrap: 17 tokens from reset leave the 4-bit count at 1.
      step("wrap_rst",   1, 0, 16'h0000, 6'h00, 6'b000000, 1, 6'b000000, 0, 6'b000000, 5);
      for (int i = 0; i < 17; i++)
         step("wrap_tok", 0, 1, 16'(16'h0200 + i), 6'h00, 6'b000000, 1, 6'b000000, 1, 6'b000000, CW'(i));
      step("wrap_end",   0, 0, 16'h0000, 6'h00, 6'b000000, 1, 6'b000000, 1, 6'b000000, 1);

      // Lazy with mixed en/sel: active = 010110.
      step("mix_go",     0, 1, 16'hbeef, 6'b110110, 6'b011110, 0, 6'b010110, 1, 6'b010110, 1);
      step("mix_idle",   0, 0, 16'h0000, 6'b110110, 6'b011110, 0, 6'b000000, 0, 6'b000000, 2);

      @(posedge CLK);
      @(negedge CLK);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fanout_fork.md
FANOUT_FORK -- requirements
Module: fanout_fork

Interface
REQ-001 Parameter NUM_OUT, default 6: number of output channels, range 1..16.
REQ-002 Parameter DATA_WIDTH, default 16: width of the data payload.
REQ-003 Parameter CNT_WIDTH, default 16: width of the transfer counter.
REQ-004 CLK  input  1: sole clock; all state updates on its rising edge.
REQ-005 RESET  input  1: synchronous, active-high reset.
REQ-006 in_valid  input  1: upstream token present.
REQ-007 in_data  input  DATA_WIDTH: upstream payload.
REQ-008 in_ready  output  1: upstream token consumed this cycle when in_valid is also high.
REQ-009 out_valid  output  NUM_OUT: per-channel token offered.
REQ-010 out_data  output  DATA_WIDTH: shared payload; equals in_data combinationally.
REQ-011 out_ready  input  NUM_OUT: per-channel downstream ready.
REQ-012 cfg_en  input  NUM_OUT: per-channel enable.
REQ-013 cfg_sel  input  NUM_OUT: per-channel route-select bit.
REQ-014 cfg_eager  input  1: 1 = eager fork; 0 = lazy fork.
REQ-015 xfer_count  output  CNT_WIDTH: count of upstream tokens consumed.

Function
REQ-016 active[i] SHALL equal cfg_en[i] & cfg_sel[i].
REQ-017 The block SHALL hold a registered done[NUM_OUT-1:0] vector that marks channels already served for the current token.
REQ-018 Per channel, rdy_ok[i] SHALL equal ~active[i] | done[i] | out_ready[i].
REQ-019 in_ready SHALL equal the AND of rdy_ok[i] over all i, and SHALL be forced to 0 while RESET is high.
REQ-020 Eager mode: out_valid[i] SHALL equal in_valid & active[i] & ~done[i].
REQ-021 Eager mode: when in_valid & in_ready, done SHALL clear to all-0 at the next edge.
REQ-022 Eager mode: otherwise, done[i] SHALL set at the next edge when out_valid[i] & out_ready[i].
REQ-023 Lazy mode: out_valid[i] SHALL equal in_valid & active[i] & in_ready, so all selected channels accept in the same cycle.
REQ-024 Lazy mode: done SHALL be held at all-0.
REQ-025 Latency SHALL be zero cycles: out_valid and out_data are combinational from the inputs. There is no data storage.
REQ-026 No active channel: in_ready SHALL be 1 and tokens SHALL be consumed and discarded, with xfer_count still incrementing.
REQ-027 xfer_count SHALL increment by 1 on each cycle with in_valid & in_ready, and SHALL wrap from all-1s to 0.
REQ-028 Each channel SHALL see exactly one handshake per token: a channel with done[i]=1 SHALL NOT assert out_valid[i].
REQ-029 Configuration inputs SHALL be changed only while done is all-0. If configuration changes while done is nonzero, done bits on newly inactive channels SHALL be ignored by rdy_ok but retained until the token completes.
REQ-030 When in_valid is low, done SHALL hold its value. Upstream SHALL NOT withdraw a presented token.
REQ-031 out_valid SHALL be all-0 while RESET is high.

Reset
REQ-032 With RESET high at a rising edge, done SHALL become all-0 and xfer_count SHALL become 0, overriding any simultaneous handshake.
REQ-033 Reset asserted mid-token SHALL discard partial-delivery state; after reset the pending token is re-offered to all active channels.

Verification
REQ-034 Lazy mode, NUM_OUT=6, active=6'b000111, out_ready=6'b000011, in_valid=1, in_data=0x1234 -> in_ready=0, out_valid=0. Then raise out_ready[2] -> in_ready=1, out_valid=6'b000111, xfer_count 0->1.
REQ-035 Eager mode, active=6'b000111, out_ready rising one channel per cycle (bit0, then bit1, then bit2) -> each channel handshakes once, done goes 001 then 011, in_ready=1 in cycle 3, then done=000 and xfer_count=1.
REQ-036 All cfg_en=0, in_valid=1 for 5 cycles -> in_ready=1 every cycle, out_valid=0, xfer_count=5.
REQ-037 CNT_WIDTH=4, 17 consumed tokens -> xfer_count=1 (wrap).
REQ-038 Eager mode, done=6'b000011, RESET pulsed with in_valid=1 -> in_ready=0 and out_valid=0 during reset. Next cycle done=0, xfer_count=0, out_valid=active.
